// File: rtl/codec_rx_pkg.sv
// Shared types and helpers for the codec record path (sample receiver and its FIFO).
package codec_rx_pkg;

    localparam int CODEC_SAMPLE_W = 16;

    typedef logic signed [CODEC_SAMPLE_W-1:0] sample_t;

    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    // Occupancy counters need one extra bit so that "full" (== depth) is representable.
    function automatic int fill_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO: dout presents the head entry whenever the FIFO is not empty.
module sample_fifo
    import codec_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic                      empty,
    output logic                      full,
    output logic [fill_w(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fill_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: storage is deliberately not reset; count gates everything observable, so stale data never leaks out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/codec_sample_receiver.sv
// Captures one ADC sample per AC97 frame (with decimation) into a FIFO drained over valid/ready.
// Optional peak-magnitude tracker enabled by defining CODEC_RX_PEAK_HOLD_EN.
module codec_sample_receiver
    import codec_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = CODEC_SAMPLE_W,
    parameter int DECIM = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_frame,
    input  logic [WIDTH-1:0]          sample_in,
    input  logic                      capture_enable,
    output logic [WIDTH-1:0]          sample_out,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic [fill_w(DEPTH)-1:0]  fill_level,
    output logic                      overflow,
    input  logic                      clear_overflow
`ifdef CODEC_RX_PEAK_HOLD_EN
    ,
    output logic [WIDTH-1:0]          peak_level,
    input  logic                      peak_clear
`endif
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic          new_frame_q;
    logic          frame_edge;
    logic [DW-1:0] dec_cnt;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          drop;
    logic          fifo_empty;
    logic          fifo_full;

    // new_frame can stay high for several cycles; only its rising edge marks a frame.
    assign frame_edge = new_frame & ~new_frame_q;
    assign push_req   = frame_edge & capture_enable & (dec_cnt == '0);
    assign pop        = sample_ready & ~fifo_empty;
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign push_ok    = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            new_frame_q <= 1'b0;
            dec_cnt     <= '0;
            overflow    <= 1'b0;
        end else begin
            new_frame_q <= new_frame;
            if (!capture_enable)
                dec_cnt <= '0;
            else if (frame_edge)
                dec_cnt <= (dec_cnt == DW'(DECIM - 1)) ? '0 : dec_cnt + DW'(1);
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop),
        .din   (sample_in),
        .dout  (sample_out),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fill_level)
    );

    assign sample_valid = ~fifo_empty;

`ifdef CODEC_RX_PEAK_HOLD_EN
    localparam logic [WIDTH-1:0] MAG_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] sample_mag;

    // The most negative code has no positive twin, so it saturates.
    always_comb begin
        sample_mag = sample_in;
        if (sample_in == NEG_MIN)
            sample_mag = MAG_MAX;
        else if (sample_in[WIDTH-1])
            sample_mag = ~sample_in + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            peak_level <= '0;
        else if (push_ok && (peak_clear || sample_mag > peak_level))
            peak_level <= sample_mag;
        else if (peak_clear)
            peak_level <= '0;
    end
`endif

endmodule

// File: tb/tb_codec_sample_receiver.sv
// Scoreboard bench for codec_sample_receiver: a DECIM=1 instance and a DECIM=3 instance.
module tb_codec_sample_receiver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DECIM=1 instance
    logic        frame1, cap1, rdy1, clr1;
    logic [15:0] smp1, out1;
    logic        vld1, ovf1;
    logic [4:0]  fill1;
    // DECIM=3 instance
    logic        frame3, cap3, rdy3, clr3;
    logic [15:0] smp3, out3;
    logic        vld3, ovf3;
    logic [4:0]  fill3;
`ifdef CODEC_RX_PEAK_HOLD_EN
    logic [15:0] peak1, peak3;
    logic        pclr1;
    logic [15:0] pk_in  [3] = '{16'h0010, 16'hFFF0, 16'h8000};
    logic [15:0] pk_exp [3] = '{16'h0010, 16'h0010, 16'h7FFF};
`endif

    logic [15:0] q1[$];
    logic [15:0] q3[$];
    int n_checks = 0;
    int n_pass   = 0;

    codec_sample_receiver #(.DEPTH(16), .WIDTH(16), .DECIM(1)) dut (
        .clk(clk), .reset(reset), .new_frame(frame1), .sample_in(smp1),
        .capture_enable(cap1), .sample_out(out1), .sample_valid(vld1),
        .sample_ready(rdy1), .fill_level(fill1), .overflow(ovf1),
        .clear_overflow(clr1)
`ifdef CODEC_RX_PEAK_HOLD_EN
        , .peak_level(peak1), .peak_clear(pclr1)
`endif
    );

    codec_sample_receiver #(.DEPTH(16), .WIDTH(16), .DECIM(3)) dut_d3 (
        .clk(clk), .reset(reset), .new_frame(frame3), .sample_in(smp3),
        .capture_enable(cap3), .sample_out(out3), .sample_valid(vld3),
        .sample_ready(rdy3), .fill_level(fill3), .overflow(ovf3),
        .clear_overflow(clr3)
`ifdef CODEC_RX_PEAK_HOLD_EN
        , .peak_level(peak3), .peak_clear(1'b0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One new_frame pulse (one high cycle, one low cycle) on the chosen instance.
    task automatic frame(input bit on_d3, input logic [15:0] v, input bit exp_push);
        if (!on_d3) begin
            if (exp_push) q1.push_back(v);
            frame1 = 1'b1;
            smp1   = v;
        end else begin
            if (exp_push) q3.push_back(v);
            frame3 = 1'b1;
            smp3   = v;
        end
        step();
        frame1 = 1'b0;
        frame3 = 1'b0;
        step();
    endtask

    // Pops happen at the next rising edge; inputs are stable across the falling edge.
    always @(negedge clk) begin
        if (reset && vld1 && rdy1) begin
            check("pop1_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) check("pop1_data", 32'(out1), 32'(q1.pop_front()));
        end
        if (reset && vld3 && rdy3) begin
            check("pop3_expected", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) check("pop3_data", 32'(out3), 32'(q3.pop_front()));
        end
    end

    initial begin
        reset = 1'b0;
        {frame1, cap1, rdy1, clr1, frame3, cap3, rdy3, clr3} = '0;
        smp1 = '0;
        smp3 = '0;
`ifdef CODEC_RX_PEAK_HOLD_EN
        pclr1 = 1'b0;
`endif
        repeat (3) step();
        reset = 1'b1;
        cap1  = 1'b1;
        cap3  = 1'b1;
        step();
        check("rst_valid", 32'(vld1), 32'd0);
        check("rst_out",   32'(out1), 32'd0);
        check("rst_fill",  32'(fill1), 32'd0);
        check("rst_ovf",   32'(ovf1), 32'd0);

        // Single frames with the consumer always ready
        rdy1 = 1'b1;
        begin
            logic [15:0] vals [3] = '{16'h0100, 16'h8000, 16'h7FFF};
            for (int i = 0; i < 3; i++) begin
                q1.push_back(vals[i]);
                frame1 = 1'b1;
                smp1   = vals[i];
                step();
                check("t1_valid", 32'(vld1), 32'd1);
                check("t1_out",   32'(out1), 32'(vals[i]));
                check("t1_fill",  32'(fill1), 32'd1);
                frame1 = 1'b0;
                step();
                check("t1_drained", 32'(fill1), 32'd0);
            end
        end

        // new_frame held high for 5 cycles yields exactly one push
        rdy1 = 1'b0;
        q1.push_back(16'h1234);
        frame1 = 1'b1;
        smp1   = 16'h1234;
        repeat (5) step();
        frame1 = 1'b0;
        step();
        check("t2_fill", 32'(fill1), 32'd1);
        check("t2_out",  32'(out1), 32'h1234);
        rdy1 = 1'b1;
        step();
        rdy1 = 1'b0;
        check("t2_drained", 32'(fill1), 32'd0);

        // Overflow: 17 frames into 16 entries, last one dropped
        for (int i = 0; i < 17; i++) frame(1'b0, 16'(i), i < 16);
        check("t4_fill", 32'(fill1), 32'd16);
        check("t4_ovf",  32'(ovf1), 32'd1);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        check("t4_ovf_clr", 32'(ovf1), 32'd0);

        // Full FIFO: push and pop on the same edge
        rdy1   = 1'b1;
        frame1 = 1'b1;
        smp1   = 16'hAAAA;
        q1.push_back(16'hAAAA);
        step();
        rdy1   = 1'b0;
        frame1 = 1'b0;
        check("t5_fill", 32'(fill1), 32'd16);
        check("t5_ovf",  32'(ovf1), 32'd0);
        step();
        rdy1 = 1'b1;
        repeat (15) step();
        rdy1 = 1'b0;
        check("t5_fill_last", 32'(fill1), 32'd1);
        check("t5_head",      32'(out1), 32'hAAAA);
        for (int i = 0; i < 16; i++) frame(1'b0, 16'h0200 + 16'(i), i < 15);
        check("t5_refill", 32'(fill1), 32'd16);
        check("t5_ovf2",   32'(ovf1), 32'd1);

        // Reset mid-operation discards everything
        reset = 1'b0;
        step();
        reset = 1'b1;
        q1.delete();
        check("t6_valid", 32'(vld1), 32'd0);
        check("t6_fill",  32'(fill1), 32'd0);
        check("t6_ovf",   32'(ovf1), 32'd0);
        check("t6_out",   32'(out1), 32'd0);

        // Decimation by 3 on the second instance
        for (int i = 1; i <= 7; i++) frame(1'b1, 16'(i), (i % 3) == 1);
        check("d3_fill", 32'(fill3), 32'd3);
        check("d3_head", 32'(out3), 32'd1);
        cap3 = 1'b0;
        step();
        cap3 = 1'b1;
        frame(1'b1, 16'd8, 1'b1);
        check("d3_resume_fill", 32'(fill3), 32'd4);
        rdy3 = 1'b1;
        repeat (4) step();
        rdy3 = 1'b0;
        check("d3_drained",    32'(fill3), 32'd0);
        check("d3_sb_empty",   32'(q3.size()), 32'd0);

`ifdef CODEC_RX_PEAK_HOLD_EN
        check("pk_reset", 32'(peak1), 32'd0);
        rdy1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q1.push_back(pk_in[i]);
            frame1 = 1'b1;
            smp1   = pk_in[i];
            step();
            check("pk_level", 32'(peak1), 32'(pk_exp[i]));
            frame1 = 1'b0;
            step();
        end
        pclr1 = 1'b1;
        step();
        pclr1 = 1'b0;
        check("pk_clear", 32'(peak1), 32'd0);
        rdy1 = 1'b0;
`endif

        step();
        check("sb1_empty", 32'(q1.size()), 32'd0);
        check("fill1_end", 32'(fill1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/codec_sample_receiver.md
Name: codec_sample_receiver

Overview:
Record-path counterpart to the playback sample path. Captures one 16-bit ADC sample from the AC97 interface on each codec frame, with optional decimation. Buffers samples in a small synchronous FIFO and hands them to a downstream consumer (waveform display, recorder) over a valid/ready handshake. Sits between ac97_if's input sample and any design-side sample consumer.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2
WIDTH, 16, sample width in bits (signed two's complement)
DECIM, 1, keep one sample every DECIM frames; minimum 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (asserted when 0); one clock domain only
new_frame  input  1  raw new_frame from ac97_if; may be high for more than one cycle
sample_in  input  WIDTH  ADC sample from ac97_if; valid on the cycle new_frame rises
capture_enable  input  1  1 = capture frames; 0 = ignore frames
sample_out  output  WIDTH  head-of-FIFO sample
sample_valid  output  1  sample_out holds a valid sample
sample_ready  input  1  consumer accepts sample_out this cycle
fill_level  output  clog2(DEPTH)+1  number of entries held
overflow  output  1  sticky: a sample was dropped because the FIFO was full
clear_overflow  input  1  one-cycle pulse; clears overflow

Behaviour:
- Reset (reset==0 at a clk edge): FIFO empties. sample_valid=0, sample_out=0, fill_level=0, overflow=0. Decimation counter and edge-detect register go to 0.
- Frame detect: new_frame is registered. frame_edge = new_frame & ~new_frame_q. sample_in is latched on the frame_edge cycle.
- Decimation: counter runs 0..DECIM-1 and advances only on frame_edge while capture_enable=1. A push is requested when frame_edge & capture_enable & counter==0. The counter wraps from DECIM-1 to 0. With DECIM=1, every frame pushes.
- capture_enable=0: no pushes, and the counter is forced to 0. The FIFO keeps draining. After capture resumes, the first edge pushes.
- Latency: frame_edge at cycle N leads to the sample being written at edge N+1. With the FIFO empty, sample_valid=1 and sample_out equal to that sample from cycle N+1.
- Handshake: a pop occurs when sample_valid & sample_ready. While sample_valid=1 and sample_ready=0, sample_out must stay stable. sample_ready while empty is ignored.
- Ordering: first-in first-out. Read and write pointers wrap modulo DEPTH. fill_level uses a separate counter: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- Full (fill_level==DEPTH):
  - push without pop: the new sample is dropped, overflow is set, and FIFO contents are unchanged.
  - push with pop on the same cycle: the push is accepted and fill_level stays at DEPTH.
- Empty with a push and sample_ready=1 on the same cycle: no pop. The pushed sample becomes visible the next cycle.
- overflow: set by a dropped push, cleared by clear_overflow. If both occur on the same cycle, set wins.
- Reset mid-operation: buffered samples are discarded. There is no partial handshake; sample_valid drops the cycle after reset is sampled.

Optional Feature:
CODEC_RX_PEAK_HOLD_EN
- Defined: adds two ports.
  - output peak_level [WIDTH-1:0]: running maximum of |sample| over pushed (not dropped) samples. |-2^(WIDTH-1)| saturates to 2^(WIDTH-1)-1. Updates one cycle after the push.
  - input peak_clear: synchronous clear to 0. A clear and an update on the same cycle load the new |sample|.
  - peak_level resets to 0.
- Undefined: neither port exists and there is no peak logic. All other behaviour is identical.

Decomposition:
- Package codec_rx_pkg:
  - CODEC_SAMPLE_W=16
  - sample typedef: signed [15:0]
  - localparam helper for the fill_level width
  - SAMPLE_MAX/SAMPLE_MIN constants
- Sub-module sample_fifo: synchronous show-ahead FIFO with parameters DEPTH and WIDTH. Ports: push, pop, din, dout, empty, full, count.
- The top level holds edge detect, decimation, overflow logic and the optional peak logic.

Test Plan:
- DEPTH=16, DECIM=1, sample_ready=1. Pulse new_frame 3 times with sample_in=0x0100, 0x8000, 0x7FFF. Expect sample_out to show those values in order, valid one cycle after each edge, fill_level peaking at 1.
- new_frame held high 5 cycles with sample_in=0x1234. Expect exactly one push and fill_level=1.
- DECIM=3, capture_enable=1, 7 edges with samples 1..7, sample_ready=0. Expect FIFO contents 1, 4, 7 and fill_level=3. Then drop capture_enable, raise it again, and send edge 8: expect 8 pushed.
- sample_ready=0, 17 edges with samples 0..16. Expect fill_level=16, overflow=1, and drained order 0..15 (16 dropped). Pulse clear_overflow: expect overflow=0.
- FIFO full with sample_ready=1 on the same cycle as an edge carrying 0xAAAA. Expect one pop, 0xAAAA accepted, fill_level stays 16, overflow stays 0. Then drive reset=0 for one cycle: expect sample_valid=0, fill_level=0, overflow=0.
- With CODEC_RX_PEAK_HOLD_EN: push 0x0010, then 0xFFF0, then 0x8000. Expect peak_level 0x0010, 0x0010, 0x7FFF. Pulse peak_clear: expect 0.
